// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with explicit release.
// A 3-bit winner index is registered and decoded to a one-hot grant.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN;
// MAX_HOLD (1..255) sets the longest grant in that build.
//
// Handshake: a grant is live while grant_valid=1. It ends at the first
// rising edge where done=1 or req[grant_idx]=0, or, with the timeout
// built in, when the hold limit expires. Every grant is followed by one
// idle cycle before the next arbitration.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant_oh,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Reject hold limits outside the 8-bit counter range at elaboration.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter8: MAX_HOLD must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       found;
    logic       release_now;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
`endif

    // Rotating priority search: first set request starting at ptr_q.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign release_now = done || !req[idx_q];

    // Next-state logic: arbitrate in IDLE, watch for release in GRANT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win_idx;
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d   = idx_q + 3'd1;
                    state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_q == HOLD_LAST) begin
                    // Forced revoke advances the pointer like a release.
                    ptr_d     = idx_q + 3'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and winner registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and registered one-cycle revoke pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Outputs decode registered state only, so they cannot glitch.
    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = idx_q;
    assign grant_oh    = grant_valid ? (8'b0000_0001 << idx_q) : 8'h00;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter for one shared resource.
- Registers a 3-bit winner index and expands it to a one-hot grant, using the same decode as the team's 3-to-8 decoder (8'b0000_0001 << index).
- Sits between up to 8 client blocks and a single shared resource (bus, LED row driver, memory port).
- Provides fair, starvation-free access with explicit release, plus an optional hold timeout.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held when the timeout feature is compiled in; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
req  input  8  request vector; bit i = requester i wants the resource
done  input  1  grantee releases the resource; sampled only while grant_valid=1
grant_valid  output  1  a grant is active
grant_idx  output  3  index of the current grantee; holds its last value when grant_valid=0
grant_oh  output  8  one-hot grant = (8'b1 << grant_idx) when grant_valid=1, else 8'h00
timeout  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - state=IDLE, ptr=0, grant_idx=0, grant_valid=0, grant_oh=8'h00, timeout=0, hold_cnt=0.
- ptr: 3-bit round-robin start pointer.
- Search order: ptr, ptr+1, ..., ptr+7, all modulo 8 (7 wraps to 0). The first set req bit in that order wins.
- IDLE state:
  - If req != 0 at a rising edge: load grant_idx with the winner, set grant_valid=1, clear hold_cnt, go to GRANT.
  - Latency: 1 cycle from req sampled high to grant_valid high.
  - If req == 0: remain in IDLE; outputs unchanged.
- GRANT state:
  - Release condition at a rising edge: done=1, or req[grant_idx]=0.
  - On release: grant_valid=0, ptr=grant_idx+1 mod 8, go to IDLE.
  - Result: exactly one bubble cycle with grant_valid=0 between consecutive grants, even when other requests are pending.
  - Requests from non-granted clients never preempt an active grant.
  - done while in IDLE is ignored.
- grant_oh is a pure decode of registered state: glitch-free and aligned with grant_valid.
- Simultaneous events: a release and a new request on the same edge follow the release rule; the new request is arbitrated on the next edge from IDLE using the updated ptr.
- Fairness: any requester holding req high is granted within 8 grant cycles.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - 8-bit hold_cnt increments each cycle in GRANT.
  - If no release has occurred and hold_cnt == MAX_HOLD-1 at an edge, the grant is forcibly released: ptr advances as for a normal release, return to IDLE.
  - timeout=1 for exactly that following cycle.
  - grant_valid is therefore high for at most MAX_HOLD cycles.
  - done or a req drop on the same edge counts as a normal release; timeout stays 0.
- Undefined:
  - No hold_cnt logic.
  - timeout is tied to 0.
  - A grant is held until done or req drop, indefinitely if needed.

Test Plan:
1. Reset: rst=1 with req=8'hFF -> grant_valid=0, grant_oh=8'h00, timeout=0. Asserting rst while a grant is active clears grant_valid in the same cycle, without waiting for a clock edge.
2. Single request: ptr=0, req=8'b0000_0100 -> next edge grant_idx=2, grant_oh=8'b0000_0100. Pulse done for 1 cycle -> grant_valid=0 next cycle, ptr=3.
3. Round robin: req=8'hFF held, done pulsed on each grant's first cycle -> grant_idx sequence 0,1,2,...,7,0 with exactly one bubble between grants.
4. Wrap-around: grant 6 then release (ptr=7), req=8'b0100_0001 -> grant_idx=0, not 6.
5. Request drop: requester 3 granted, then req[3] deasserted with done=0 -> grant_valid falls at that edge, ptr=4. Pending req[1] is granted after one bubble.
6. Timeout: build with ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'b0000_0010 held, done=0 -> grant_valid high exactly 4 cycles, then timeout=1 for one cycle with ptr=2, then 1 is re-granted. Build without the macro -> grant held for 100+ cycles and timeout stays 0.
